// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Holds the hardware thread count, the thread-ID width/type and the
// scheduler FSM state encoding. The instruction-pointer block reuses TID_W.
package cpu_pkg;

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned TID_W       = 2;

  typedef logic [TID_W-1:0] tid_t;

  typedef enum logic {
    StIdle,
    StRun
  } sched_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Four-way rotating priority picker (purely combinational).
// Ports:
//   req         in   per-thread request vector
//   ptr         in   last granted thread; search starts at ptr+1
//   grant_tid   out  first requester in order ptr+1, ptr+2, ptr+3, ptr
//                    (ptr itself when nothing requests)
//   grant_valid out  any request present
module rr_pick4 import cpu_pkg::*; (
  input  logic [3:0] req,
  input  tid_t       ptr,
  output tid_t       grant_tid,
  output logic       grant_valid
);

  always_comb begin
    tid_t cand;
    cand        = '0;
    grant_valid = 1'b0;
    grant_tid   = ptr;
    // i = 4 wraps back onto ptr, so ptr has the lowest priority.
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + tid_t'(i);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_tid   = cand;
      end
    end
  end

endmodule

// File: rtl/thread_sched_4way.sv
// Fine-grained multithreading scheduler for the 4-thread front end.
// Picks one eligible (active and not blocked) thread per cycle in round-robin
// order and drives it, with a fetch enable, into the instruction-pointer block.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, thread_mask       launch a run with the given thread set (IDLE only)
//   stall                    global stall: no issue, rotation pointer frozen
//   block_req, block_tid     thread hit a control transfer; block it
//   resolve, resolve_tid     control transfer resolved; unblock it
//   halt, halt_tid           thread retired
//   issue_tid, issue_en      selected thread and fetch enable
//   active, busy             registered active mask and its OR
//   done                     one-cycle pulse when the last thread halts
module thread_sched_4way #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_W       = 2,
  parameter int unsigned BLOCK_MAX   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_THREADS-1:0] thread_mask,
  input  logic                   stall,
  input  logic                   block_req,
  input  logic [TID_W-1:0]       block_tid,
  input  logic                   resolve,
  input  logic [TID_W-1:0]       resolve_tid,
  input  logic                   halt,
  input  logic [TID_W-1:0]       halt_tid,
  output logic [TID_W-1:0]       issue_tid,
  output logic                   issue_en,
  output logic [NUM_THREADS-1:0] active,
  output logic                   busy,
  output logic                   done
);
  import cpu_pkg::*;

  localparam int unsigned CntW = $clog2(BLOCK_MAX + 1);

  sched_state_e           state_q, state_d;
  logic [NUM_THREADS-1:0] active_q, active_d;
  logic [NUM_THREADS-1:0] blocked_q, blocked_d;
  logic [CntW-1:0]        cnt_q [NUM_THREADS];
  logic [CntW-1:0]        cnt_d [NUM_THREADS];
  tid_t                   ptr_q, ptr_d;
  logic                   done_q, done_d;

  logic [NUM_THREADS-1:0] elig;
  tid_t                   pick_tid;
  logic                   pick_valid;
  logic                   run;

  assign run  = (state_q == StRun);
  assign elig = active_q & ~blocked_q;

  rr_pick4 u_pick (
    .req         (elig),
    .ptr         (ptr_q),
    .grant_tid   (pick_tid),
    .grant_valid (pick_valid)
  );

  assign issue_en = run & pick_valid & ~stall;
  // Forced to 0 outside a run so every output reads 0 after reset.
  assign issue_tid = run ? pick_tid : '0;
  assign active    = active_q;
  assign busy      = |active_q;
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    blocked_d = blocked_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;

    if (issue_en) begin
      ptr_d = issue_tid;
    end

    // Block timeout runs regardless of stall.
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (blocked_q[t] && (cnt_q[t] != '0)) begin
        cnt_d[t] = cnt_q[t] - 1'b1;
        if (cnt_d[t] == '0) begin
          blocked_d[t] = 1'b0;
        end
      end
    end

    // Later assignments win: halt > block_req > resolve for the same thread.
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (active_q[t]) begin
        if (resolve && (resolve_tid == TID_W'(t))) begin
          blocked_d[t] = 1'b0;
          cnt_d[t]     = '0;
        end
        if (block_req && (block_tid == TID_W'(t))) begin
          blocked_d[t] = 1'b1;
          cnt_d[t]     = CntW'(BLOCK_MAX);
        end
        if (halt && (halt_tid == TID_W'(t))) begin
          active_d[t]  = 1'b0;
          blocked_d[t] = 1'b0;
          cnt_d[t]     = '0;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start && (|thread_mask)) begin
          state_d   = StRun;
          active_d  = thread_mask;
          blocked_d = '0;
          for (int t = 0; t < NUM_THREADS; t++) begin
            cnt_d[t] = '0;
          end
          // ptr = last thread so the first search starts at thread 0.
          ptr_d = tid_t'(NUM_THREADS - 1);
        end
      end
      StRun: begin
        if (active_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      active_q  <= '0;
      blocked_q <= '0;
      ptr_q     <= tid_t'(NUM_THREADS - 1);
      done_q    <= 1'b0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        cnt_q[t] <= '0;
      end
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      blocked_q <= blocked_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      for (int t = 0; t < NUM_THREADS; t++) begin
        cnt_q[t] <= cnt_d[t];
      end
    end
  end

endmodule

// File: tb/tb_thread_sched_4way.sv
// Self-checking bench for thread_sched_4way: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model that tracks per-thread "blocked until cycle" deadlines.
module tb_thread_sched_4way;
  localparam int BMAX = 4;

  logic       clk = 1'b0;
  logic       rst, start, stall, block_req, resolve, halt;
  logic [3:0] thread_mask;
  logic [1:0] block_tid, resolve_tid, halt_tid;
  logic [1:0] issue_tid;
  logic       issue_en, busy, done;
  logic [3:0] active;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  thread_sched_4way #(
    .NUM_THREADS (4),
    .TID_W       (2),
    .BLOCK_MAX   (BMAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .thread_mask (thread_mask),
    .stall       (stall),
    .block_req   (block_req),
    .block_tid   (block_tid),
    .resolve     (resolve),
    .resolve_tid (resolve_tid),
    .halt        (halt),
    .halt_tid    (halt_tid),
    .issue_tid   (issue_tid),
    .issue_en    (issue_en),
    .active      (active),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural model: a thread is blocked while m_cyc <= m_blk_end[t].
  bit       m_run = 1'b0;
  bit [3:0] m_act = 4'b0;
  int       m_blk_end [4] = '{-1, -1, -1, -1};
  int       m_ptr = 3;
  bit       m_done = 1'b0;
  int       m_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void model_issue(input bit stl, output bit en, output int tid);
    bit found;
    int pick;
    int t;
    found = 1'b0;
    pick  = m_ptr;
    for (int k = 1; k <= 4; k++) begin
      t = (m_ptr + k) % 4;
      if (!found && m_run && m_act[t] && (m_cyc > m_blk_end[t])) begin
        found = 1'b1;
        pick  = t;
      end
    end
    en  = m_run && found && !stl;
    tid = m_run ? pick : 0;
  endfunction

  // Mid-cycle: compare against the model, then advance the model with the
  // inputs the DUT will sample at the coming posedge.
  always @(negedge clk) begin
    bit       e_en;
    int       e_tid;
    bit [3:0] na;
    model_issue(stall, e_en, e_tid);
    chk("issue_en", issue_en, e_en);
    chk("issue_tid", issue_tid, e_tid);
    chk("active", active, m_act);
    chk("busy", busy, |m_act);
    chk("done", done, m_done);

    if (rst) begin
      m_run = 1'b0;
      m_act = '0;
      m_ptr = 3;
      m_done = 1'b0;
      for (int t = 0; t < 4; t++) m_blk_end[t] = -1;
    end else begin
      if (e_en) m_ptr = e_tid;
      na = m_act;
      if (resolve && m_act[resolve_tid]) m_blk_end[resolve_tid] = -1;
      if (block_req && m_act[block_tid]) m_blk_end[block_tid] = m_cyc + BMAX;
      if (halt && m_act[halt_tid]) begin
        na[halt_tid] = 1'b0;
        m_blk_end[halt_tid] = -1;
      end
      m_done = 1'b0;
      if (!m_run) begin
        if (start && (thread_mask != 0)) begin
          m_run = 1'b1;
          na    = thread_mask;
          m_ptr = 3;
          for (int t = 0; t < 4; t++) m_blk_end[t] = -1;
        end
      end else if (na == 0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
      m_act = na;
    end
    m_cyc++;
  end

  // Start a new cycle: just after posedge, clear all event inputs.
  task automatic nx();
    @(posedge clk);
    #1;
    rst = 0; start = 0; thread_mask = 0; stall = 0;
    block_req = 0; block_tid = 0; resolve = 0; resolve_tid = 0; halt = 0; halt_tid = 0;
  endtask

  // Observation point for the current cycle.
  task automatic ob();
    @(negedge clk);
  endtask

  int s2_tid [7] = '{1, 3, 1, 1, 1, 1, 3};
  int s2_en  [7] = '{1, 1, 0, 0, 0, 1, 1};
  int s3_tid [7] = '{2, 3, 0, 2, 3, 0, 1};

  initial begin
    rst = 1; start = 0; thread_mask = 0; stall = 0;
    block_req = 0; block_tid = 0; resolve = 0; resolve_tid = 0; halt = 0; halt_tid = 0;

    // Reset state
    nx(); rst = 1; ob();
    chk("rst issue_en", issue_en, 0);
    chk("rst issue_tid", issue_tid, 0);
    chk("rst active", active, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);

    // Full mask, plain rotation
    nx(); start = 1; thread_mask = 4'b1111; ob();
    chk("s1 start cycle en", issue_en, 0);
    for (int i = 0; i < 5; i++) begin
      nx(); ob();
      chk("s1 tid", issue_tid, i % 4);
      chk("s1 en", issue_en, 1);
    end

    // Mask 1010 with stall in cycles 3..5
    nx(); rst = 1; ob();
    nx(); start = 1; thread_mask = 4'b1010; ob();
    for (int c = 1; c <= 7; c++) begin
      nx(); stall = (c >= 3 && c <= 5); ob();
      chk("s2 en", issue_en, s2_en[c-1]);
      chk("s2 tid", issue_tid, s2_tid[c-1]);
    end

    // Block tid 1 with timeout, then again with an early resolve
    nx(); rst = 1; ob();
    nx(); start = 1; thread_mask = 4'b1111; ob();
    nx(); block_req = 1; block_tid = 1; ob();
    chk("s3 block cycle tid", issue_tid, 0);
    for (int c = 0; c < 7; c++) begin
      nx(); ob();
      chk("s3 tid", issue_tid, s3_tid[c]);
    end
    nx(); block_req = 1; block_tid = 1; ob();
    chk("s3b tid", issue_tid, 2);
    nx(); ob();
    chk("s3b tid", issue_tid, 3);
    nx(); resolve = 1; resolve_tid = 1; ob();
    chk("s3b resolve cycle tid", issue_tid, 0);
    nx(); ob();
    chk("s3b after resolve tid", issue_tid, 1);

    // Halt 0, 2, 3, 1
    nx(); halt = 1; halt_tid = 0; ob();
    nx(); halt = 1; halt_tid = 2; ob();
    chk("s4 active", active, 4'b1110);
    nx(); halt = 1; halt_tid = 3; ob();
    chk("s4 active", active, 4'b1010);
    nx(); halt = 1; halt_tid = 1; ob();
    chk("s4 active", active, 4'b0010);
    chk("s4 done early", done, 0);
    nx(); ob();
    chk("s4 active", active, 4'b0000);
    chk("s4 done", done, 1);
    chk("s4 busy", busy, 0);
    nx(); start = 1; thread_mask = 4'b0000; ob();
    chk("s4 done once", done, 0);
    nx(); start = 1; thread_mask = 4'b0001; ob();
    chk("s4 zero mask ignored", active, 0);
    nx(); ob();
    chk("s4 restart tid", issue_tid, 0);
    chk("s4 restart en", issue_en, 1);

    // Same-cycle events: halt+block tid 2, resolve tid 0
    nx(); rst = 1; ob();
    nx(); start = 1; thread_mask = 4'b1111; ob();
    nx(); block_req = 1; block_tid = 0; ob();
    nx(); halt = 1; halt_tid = 2; block_req = 1; block_tid = 2; resolve = 1; resolve_tid = 0; ob();
    chk("s5 tid", issue_tid, 1);
    nx(); ob();
    chk("s5 active", active, 4'b1011);
    chk("s5 tid", issue_tid, 3);
    nx(); ob();
    chk("s5 resolved tid", issue_tid, 0);

    // Reset mid-run
    nx(); rst = 1; ob();
    nx(); ob();
    chk("s6 en", issue_en, 0);
    chk("s6 tid", issue_tid, 0);
    chk("s6 active", active, 0);
    chk("s6 busy", busy, 0);
    chk("s6 done", done, 0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      nx();
      rst         = ($urandom % 200) == 0;
      start       = ($urandom % 4) == 0;
      thread_mask = 4'($urandom);
      stall       = ($urandom % 5) == 0;
      block_req   = ($urandom % 4) == 0;
      block_tid   = 2'($urandom);
      resolve     = ($urandom % 4) == 0;
      resolve_tid = 2'($urandom);
      halt        = ($urandom % 12) == 0;
      halt_tid    = 2'($urandom);
      ob();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
